// File: rtl/ceres_param.sv
// Shared core parameters and types.
//   XLEN            data path width
//   FQ_DEPTH        fetch->decode instruction queue depth
//   exc_type_e      fetch/decode exception codes
//   instr_type_e    resolved instruction class
//   predict_info_t  branch prediction attached to a fetched PC
//   fq_entry_t      one fetch queue entry
package ceres_param;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

    typedef enum logic [3:0] {
        NO_EXCEPTION        = 4'd0,
        INSTR_MISALIGNED    = 4'd1,
        INSTR_ACCESS_FAULT  = 4'd2,
        ILLEGAL_INSTRUCTION = 4'd3,
        BREAKPOINT          = 4'd4
    } exc_type_e;

    // INSTR_INVALID is the default/idle value.
    typedef enum logic [2:0] {
        INSTR_INVALID = 3'd0,
        R_TYPE        = 3'd1,
        I_TYPE        = 3'd2,
        S_TYPE        = 3'd3,
        B_TYPE        = 3'd4,
        U_TYPE        = 3'd5,
        J_TYPE        = 3'd6
    } instr_type_e;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } predict_info_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_incr;
        logic [XLEN-1:0] inst;
        exc_type_e       exc;
        instr_type_e     instr_type;
        predict_info_t   spec;
    } fq_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// Decoupling queue between fetch and decode.
// Fetch pushes one fully formed instruction per cycle; decode pops in order.
// A faulting instruction locks the queue against younger entries until flush.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   flush_i                 synchronous clear (highest priority)
//   enq_valid_i/enq_ready_o enqueue handshake, enq_* payload fields
//   deq_valid_o/deq_ready_i dequeue handshake, deq_* head fields (NOP when empty)
//   count_o                 occupied entries, 0..DEPTH
module fetch_inst_queue
    import ceres_param::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = ceres_param::XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [XLEN-1:0]          enq_pc_incr_i,
    input  logic [XLEN-1:0]          enq_inst_i,
    input  exc_type_e                enq_exc_i,
    input  instr_type_e              enq_instr_type_i,
    input  predict_info_t            enq_spec_i,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [XLEN-1:0]          deq_pc_incr_o,
    output logic [XLEN-1:0]          deq_inst_o,
    output exc_type_e                deq_exc_o,
    output instr_type_e              deq_instr_type_o,
    output predict_info_t            deq_spec_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Extra MSB on each pointer is the wrap bit, distinguishing full from empty.
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          exc_lock;
    fq_entry_t     mem [DEPTH];

    logic empty, full, enq_fire, deq_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    assign enq_ready_o = !full && !exc_lock && !flush_i;
    assign deq_valid_o = !empty;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    // Flush discards a same-cycle pop; enq_fire already excludes flush.
    assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;
    assign count_o     = wr_ptr - rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            exc_lock <= 1'b0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            exc_lock <= 1'b0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
            // Nothing younger may enter behind a faulting instruction.
            if (enq_fire && enq_exc_i != NO_EXCEPTION) exc_lock <= 1'b1;
        end
    end

    // Payload is not reset; validity comes only from the pointers.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wr_ptr[AW-1:0]] <= '{pc:         enq_pc_i,
                                     pc_incr:    enq_pc_incr_i,
                                     inst:       enq_inst_i,
                                     exc:        enq_exc_i,
                                     instr_type: enq_instr_type_i,
                                     spec:       enq_spec_i};
        end
    end

    // Empty queue presents a clean NOP so decode never sees stale payload.
    always_comb begin
        deq_pc_o         = '0;
        deq_pc_incr_o    = '0;
        deq_inst_o       = 32'h0000_0013;
        deq_exc_o        = NO_EXCEPTION;
        deq_instr_type_o = INSTR_INVALID;
        deq_spec_o       = '0;
        if (!empty) begin
            deq_pc_o         = mem[rd_ptr[AW-1:0]].pc;
            deq_pc_incr_o    = mem[rd_ptr[AW-1:0]].pc_incr;
            deq_inst_o       = mem[rd_ptr[AW-1:0]].inst;
            deq_exc_o        = mem[rd_ptr[AW-1:0]].exc;
            deq_instr_type_o = mem[rd_ptr[AW-1:0]].instr_type;
            deq_spec_o       = mem[rd_ptr[AW-1:0]].spec;
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
module tb_fetch_inst_queue;
    import ceres_param::*;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic          enq_ready_o;
    logic [31:0]   enq_pc_i = '0, enq_pc_incr_i = '0, enq_inst_i = '0;
    exc_type_e     enq_exc_i = NO_EXCEPTION;
    instr_type_e   enq_instr_type_i = INSTR_INVALID;
    predict_info_t enq_spec_i = '0;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [31:0]   deq_pc_o, deq_pc_incr_o, deq_inst_o;
    exc_type_e     deq_exc_o;
    instr_type_e   deq_instr_type_o;
    predict_info_t deq_spec_o;
    logic [2:0]    count_o;

    int total = 0;
    int bad   = 0;

    fetch_inst_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_pc_incr_i(enq_pc_incr_i), .enq_inst_i(enq_inst_i),
        .enq_exc_i(enq_exc_i), .enq_instr_type_i(enq_instr_type_i), .enq_spec_i(enq_spec_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_pc_incr_o(deq_pc_incr_o), .deq_inst_o(deq_inst_o),
        .deq_exc_o(deq_exc_o), .deq_instr_type_o(deq_instr_type_o), .deq_spec_o(deq_spec_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic set_enq(input logic [31:0] pc, input logic [31:0] incr, input exc_type_e exc);
        enq_valid_i   = 1'b1;
        enq_pc_i      = pc;
        enq_pc_incr_i = incr;
        enq_inst_i    = pc ^ 32'h00A5_0000;
        enq_exc_i     = exc;
    endtask

    initial begin
        // ---- 1: reset state, fill, drain in order
        @(negedge clk_i);
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid_o), 64'd0);
        chk("rst_nop", 64'(deq_inst_o), 64'h13);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            set_enq(32'h8000_0000 + 32'(4*i), 32'h8000_0004 + 32'(4*i), NO_EXCEPTION);
            step();
            chk("fill_count", 64'(count_o), 64'(i + 1));
        end
        chk("full_enq_ready", 64'(enq_ready_o), 64'd0);
        chk("full_head_pc", 64'(deq_pc_o), 64'h8000_0000);
        // Offered instruction must not enter a full queue even while popping.
        set_enq(32'hDEAD_0000, 32'hDEAD_0004, NO_EXCEPTION);
        deq_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(deq_pc_o), 64'(32'h8000_0000 + 32'(4*i)));
            chk("drain_inst", 64'(deq_inst_o), 64'((32'h8000_0000 + 32'(4*i)) ^ 32'h00A5_0000));
            if (i == 0) enq_valid_i = 1'b0;
            step();
        end
        // Only the first cycle offered while full: queue now empty.
        chk("drain_count", 64'(count_o), 64'd0);
        chk("drain_valid", 64'(deq_valid_o), 64'd0);
        chk("drain_nop", 64'(deq_inst_o), 64'h13);
        deq_ready_i = 1'b0;

        // ---- 2: steady stream, 20 instructions, pointers wrap
        set_enq(32'h1000_0000, 32'h1000_0004, NO_EXCEPTION);
        step();
        deq_ready_i = 1'b1;
        for (int k = 1; k < 20; k++) begin
            set_enq(32'h1000_0000 + 32'(4*k), 32'h1000_0004 + 32'(4*k), NO_EXCEPTION);
            #1;
            chk("stream_pc", 64'(deq_pc_o), 64'(32'h1000_0000 + 32'(4*(k-1))));
            chk("stream_count", 64'(count_o), 64'd1);
            step();
        end
        enq_valid_i = 1'b0;
        chk("stream_last_pc", 64'(deq_pc_o), 64'h1000_004C);
        step();
        chk("stream_empty", 64'(count_o), 64'd0);
        deq_ready_i = 1'b0;

        // ---- 3: exception locks the queue, flush clears it
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h2000_0000 + 32'(4*i), 32'h2000_0004 + 32'(4*i),
                    (i == 2) ? ILLEGAL_INSTRUCTION : NO_EXCEPTION);
            step();
        end
        chk("lock_ready", 64'(enq_ready_o), 64'd0);
        set_enq(32'h2000_000C, 32'h2000_0010, NO_EXCEPTION);
        step();
        chk("lock_count", 64'(count_o), 64'd3);
        enq_valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_ready", 64'(enq_ready_o), 64'd1);

        // ---- 4: flush on a full queue beats same-cycle enq/deq
        for (int i = 0; i < 4; i++) begin
            set_enq(32'h3000_0000 + 32'(4*i), 32'h3000_0004 + 32'(4*i), NO_EXCEPTION);
            step();
        end
        chk("f4_count", 64'(count_o), 64'd4);
        set_enq(32'h3000_0010, 32'h3000_0014, NO_EXCEPTION);
        deq_ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        #1;
        chk("f4_valid", 64'(deq_valid_o), 64'd0);
        chk("f4_nop", 64'(deq_inst_o), 64'h13);
        chk("f4_count0", 64'(count_o), 64'd0);
        chk("f4_exc", 64'(deq_exc_o), 64'(NO_EXCEPTION));

        // ---- 5: asynchronous reset mid-cycle with 3 entries
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h4000_0000 + 32'(4*i), 32'h4000_0004 + 32'(4*i), NO_EXCEPTION);
            step();
        end
        enq_valid_i = 1'b0;
        chk("r5_pre", 64'(count_o), 64'd3);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("r5_count", 64'(count_o), 64'd0);
        chk("r5_valid", 64'(deq_valid_o), 64'd0);
        chk("r5_nop", 64'(deq_inst_o), 64'h13);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("r5_ready", 64'(enq_ready_o), 64'd1);

        // ---- 6: compressed entry then taken prediction
        @(negedge clk_i);
        set_enq(32'h0000_0100, 32'h0000_0102, NO_EXCEPTION);
        enq_instr_type_i = I_TYPE;
        enq_spec_i = '{taken: 1'b0, target: 32'h0};
        step();
        set_enq(32'h0000_0102, 32'h0000_0106, NO_EXCEPTION);
        enq_instr_type_i = B_TYPE;
        enq_spec_i = '{taken: 1'b1, target: 32'h0000_0200};
        step();
        enq_valid_i = 1'b0;
        chk("c6_incr", 64'(deq_pc_incr_o), 64'h102);
        chk("c6_taken0", 64'(deq_spec_o.taken), 64'd0);
        chk("c6_type0", 64'(deq_instr_type_o), 64'(I_TYPE));
        deq_ready_i = 1'b1;
        step();
        chk("c6_pc", 64'(deq_pc_o), 64'h102);
        chk("c6_incr2", 64'(deq_pc_incr_o), 64'h106);
        chk("c6_taken1", 64'(deq_spec_o.taken), 64'd1);
        chk("c6_target", 64'(deq_spec_o.target), 64'h200);
        chk("c6_type1", 64'(deq_instr_type_o), 64'(B_TYPE));
        step();
        chk("c6_empty", 64'(deq_valid_o), 64'd0);
        deq_ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
